// File: rtl/decode_writeback.sv
// decode_writeback: Y86-64 Decode stage with the architectural register file.
//   Takes the D pipeline register fields, picks the source/destination
//   registers, reads the 15-entry register file with E/M/W forwarding and
//   loads the E pipeline register. Writeback writes the register file through
//   the W_dstE/W_dstM ports.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   D_*                     decode-stage inputs (stat, icode, ifun, rA, rB, valC, valP)
//   e_/M_/W_ dst/val        forwarding sources; W_* also write the register file
//   E_bubble                load a nop bubble into E
//   d_srcA, d_srcB          combinational source selects for the hazard unit
//   E_*                     registered E pipeline fields
// Optional feature (macro DECODE_DEBUG_PORT_EN):
//   dbg_addr in / dbg_data out, raw register-file read without forwarding.
module decode_writeback #(
  parameter logic [63:0] RSP_INIT = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  D_stat,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_rA,
  input  logic [3:0]  D_rB,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [63:0] M_valE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [63:0] W_valE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valM,
  input  logic        E_bubble,
`ifdef DECODE_DEBUG_PORT_EN
  input  logic [3:0]  dbg_addr,
  output logic [63:0] dbg_data,
`endif
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  E_stat,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] S_AOK = 4'b1000;
  localparam logic [3:0] I_NOP = 4'h1;

  logic [63:0] rf [0:14];

  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic [63:0] rd_a, rd_b, val_a, val_b;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (D_icode)
      4'h2, 4'h4, 4'h6, 4'hA: src_a = D_rA;
      4'h9, 4'hB:             src_a = RRSP;
      default:                src_a = RNONE;
    endcase
    case (D_icode)
      4'h4, 4'h5, 4'h6:       src_b = D_rB;
      4'h8, 4'h9, 4'hA, 4'hB: src_b = RRSP;
      default:                src_b = RNONE;
    endcase
    case (D_icode)
      4'h2, 4'h3, 4'h6:       dst_e = D_rB;
      4'h8, 4'h9, 4'hA, 4'hB: dst_e = RRSP;
      default:                dst_e = RNONE;
    endcase
    case (D_icode)
      4'h5, 4'hB:             dst_m = D_rA;
      default:                dst_m = RNONE;
    endcase
  end

  assign d_srcA = src_a;
  assign d_srcB = src_b;

  // Index F has no array entry; it reads as zero.
  assign rd_a = (src_a == RNONE) ? 64'd0 : rf[src_a];
  assign rd_b = (src_b == RNONE) ? 64'd0 : rf[src_b];

  // Forwarding chain. Youngest producer wins; M_dstM beats M_dstE because a
  // load result is the later value. The W taps also cover same-cycle
  // read-during-write, so the stale array value is never seen.
  always_comb begin
    val_a = rd_a;
    if (D_icode == 4'h7 || D_icode == 4'h8) val_a = D_valP;
    else if (src_a != RNONE) begin
      if      (src_a == e_dstE) val_a = e_valE;
      else if (src_a == M_dstM) val_a = m_valM;
      else if (src_a == M_dstE) val_a = M_valE;
      else if (src_a == W_dstM) val_a = W_valM;
      else if (src_a == W_dstE) val_a = W_valE;
    end
  end

  always_comb begin
    val_b = rd_b;
    if (src_b != RNONE) begin
      if      (src_b == e_dstE) val_b = e_valE;
      else if (src_b == M_dstM) val_b = m_valM;
      else if (src_b == M_dstE) val_b = M_valE;
      else if (src_b == W_dstM) val_b = W_valM;
      else if (src_b == W_dstE) val_b = W_valE;
    end
  end

  // The M write is issued last so it wins when both target the same
  // register (popq %rsp).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) rf[i] <= (i == 4) ? RSP_INIT : 64'd0;
    end else begin
      if (W_dstE != RNONE) rf[W_dstE] <= W_valE;
      if (W_dstM != RNONE) rf[W_dstM] <= W_valM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || E_bubble) begin
      E_stat  <= S_AOK;
      E_icode <= I_NOP;
      E_ifun  <= 4'h0;
      E_valC  <= 64'd0;
      E_valA  <= 64'd0;
      E_valB  <= 64'd0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else begin
      E_stat  <= D_stat;
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_valC  <= D_valC;
      E_valA  <= val_a;
      E_valB  <= val_b;
      E_dstE  <= dst_e;
      E_dstM  <= dst_m;
      E_srcA  <= src_a;
      E_srcB  <= src_b;
    end
  end

`ifdef DECODE_DEBUG_PORT_EN
  assign dbg_data = (dbg_addr == RNONE) ? 64'd0 : rf[dbg_addr];
`endif

endmodule

// File: tb/tb_decode_writeback.sv
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic        E_bubble;
  logic [3:0]  d_srcA, d_srcB;
  logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;
`ifdef DECODE_DEBUG_PORT_EN
  logic [3:0]  dbg_addr;
  logic [63:0] dbg_data;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  decode_writeback #(.RSP_INIT(64'h200)) dut (
    .clk(clk), .reset(reset),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM), .E_bubble(E_bubble),
`ifdef DECODE_DEBUG_PORT_EN
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
`endif
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
    .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle pattern: nop in D, all forwarding destinations F but with nonzero
  // values so a source of F matching a forward would be visible.
  task automatic idle();
    reset = 1'b0; E_bubble = 1'b0;
    D_stat = 4'b1000; D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
    D_valC = 64'd0; D_valP = 64'd0;
    e_dstE = 4'hF; e_valE = 64'hDEAD_0001;
    M_dstE = 4'hF; M_valE = 64'hDEAD_0002;
    M_dstM = 4'hF; m_valM = 64'hDEAD_0003;
    W_dstE = 4'hF; W_valE = 64'hDEAD_0004;
    W_dstM = 4'hF; W_valM = 64'hDEAD_0005;
  endtask

  task automatic decode(input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] valc, input logic [63:0] valp);
    D_icode = icode; D_ifun = ifun; D_rA = ra; D_rB = rb; D_valC = valc; D_valP = valp;
  endtask

  initial begin
    idle();
`ifdef DECODE_DEBUG_PORT_EN
    dbg_addr = 4'hF;
`endif
    #1;
    // Reset with a valid instruction present: bubble must win.
    reset = 1'b1;
    decode(4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0);
    tick();
    check("rst_icode", E_icode, 4'h1);
    check("rst_stat",  E_stat,  4'b1000);
    check("rst_dstE",  E_dstE,  4'hF);
    check("rst_srcA",  E_srcA,  4'hF);
    check("rst_valA",  E_valA,  64'd0);

    // irmovq $5, %rdx
    idle();
    decode(4'h3, 4'h0, 4'hF, 4'h2, 64'd5, 64'h0A);
    #1;
    check("irm_d_srcA", d_srcA, 4'hF);
    check("irm_d_srcB", d_srcB, 4'hF);
    tick();
    check("irm_icode", E_icode, 4'h3);
    check("irm_dstE",  E_dstE,  4'h2);
    check("irm_dstM",  E_dstM,  4'hF);
    check("irm_valC",  E_valC,  64'd5);
    check("irm_srcA",  E_srcA,  4'hF);
    check("irm_valA",  E_valA,  64'd0);
    check("irm_valB",  E_valB,  64'd0);

    // W writes reg3 = 0x11, then addq %rbx,%rcx reads it from the array.
    idle();
    W_dstE = 4'h3; W_valE = 64'h11;
    tick();
    idle();
    decode(4'h6, 4'h0, 4'h3, 4'h1, 64'h0, 64'h0);
    #1;
    check("add_d_srcA", d_srcA, 4'h3);
    check("add_d_srcB", d_srcB, 4'h1);
    tick();
    check("add_valA", E_valA, 64'h11);
    check("add_valB", E_valB, 64'd0);
    check("add_dstE", E_dstE, 4'h1);
    check("add_srcA", E_srcA, 4'h3);

    // Forwarding priority on source reg1.
    idle();
    decode(4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0);
    e_dstE = 4'h1; e_valE = 64'd7;
    M_dstE = 4'h1; M_valE = 64'd9;
    W_dstE = 4'h1; W_valE = 64'd3;
    tick();
    check("fwd_e", E_valA, 64'd7);
    e_dstE = 4'hF;
    tick();
    check("fwd_ME", E_valA, 64'd9);
    M_dstM = 4'h1; m_valM = 64'h55;
    tick();
    check("fwd_MM", E_valA, 64'h55);
    M_dstE = 4'hF; M_dstM = 4'hF;
    W_dstM = 4'h1; W_valM = 64'h66;
    tick();
    check("fwd_WM", E_valA, 64'h66);
    // Both W writes hit reg1 on that edge; the M write must have won.
    idle();
    decode(4'h6, 4'h0, 4'h1, 4'h1, 64'h0, 64'h0);
    tick();
    check("wr_collide_A", E_valA, 64'h66);
    check("wr_collide_B", E_valB, 64'h66);

    // call: valA = valP, srcB/dstE = %rsp, valB = RSP_INIT.
    idle();
    decode(4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'h40);
    tick();
    check("call_valA", E_valA, 64'h40);
    check("call_srcB", E_srcB, 4'h4);
    check("call_dstE", E_dstE, 4'h4);
    check("call_valB", E_valB, 64'h200);
    check("call_srcA", E_srcA, 4'hF);

    // popq %rsp writeback: both ports target reg4, W_valM wins.
    idle();
    W_dstE = 4'h4; W_valE = 64'd8;
    W_dstM = 4'h4; W_valM = 64'hAA;
    tick();
    idle();
`ifdef DECODE_DEBUG_PORT_EN
    dbg_addr = 4'h4;
    #1;
    check("dbg_reg4", dbg_data, 64'hAA);
    dbg_addr = 4'hF;
    #1;
    check("dbg_regF", dbg_data, 64'd0);
`endif
    // pushq %rdx reads reg4 through the array.
    decode(4'hA, 4'h0, 4'h2, 4'hF, 64'h0, 64'h0);
    tick();
    check("push_valB", E_valB, 64'hAA);
    check("push_valA", E_valA, 64'd0);
    check("push_dstE", E_dstE, 4'h4);

    // Same-cycle write and read of reg2 returns the W value.
    idle();
    decode(4'h2, 4'h0, 4'h2, 4'h5, 64'h0, 64'h0);
    W_dstE = 4'h2; W_valE = 64'h77;
    tick();
    check("rdw_valA", E_valA, 64'h77);
    check("rdw_dstE", E_dstE, 4'h5);
    check("rdw_srcB", E_srcB, 4'hF);

    // popq %rbx: dstM = rA, src/dstE = %rsp.
    idle();
    decode(4'hB, 4'h0, 4'h3, 4'hF, 64'h0, 64'h0);
    tick();
    check("pop_dstM", E_dstM, 4'h3);
    check("pop_srcA", E_srcA, 4'h4);
    check("pop_valA", E_valA, 64'hAA);

    // Bubble over a valid pushq.
    idle();
    decode(4'hA, 4'h0, 4'h2, 4'hF, 64'h0, 64'h0);
    D_stat = 4'b0001;
    E_bubble = 1'b1;
    tick();
    check("bub_icode", E_icode, 4'h1);
    check("bub_dstE",  E_dstE,  4'hF);
    check("bub_stat",  E_stat,  4'b1000);
    check("bub_valA",  E_valA,  64'd0);

    // Non-AOK status passes through.
    idle();
    decode(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    D_stat = 4'b0010;
    tick();
    check("stat_adr", E_stat, 4'b0010);

    // Unknown icode: no sources/destinations, fields pass through.
    idle();
    decode(4'hC, 4'h5, 4'h1, 4'h2, 64'h1234, 64'h0);
    tick();
    check("unk_icode", E_icode, 4'hC);
    check("unk_ifun",  E_ifun,  4'h5);
    check("unk_valC",  E_valC,  64'h1234);
    check("unk_srcA",  E_srcA,  4'hF);
    check("unk_dstE",  E_dstE,  4'hF);

    // Reset with a concurrent W write: write discarded, array reinitialised.
    idle();
    reset = 1'b1;
    W_dstE = 4'h2; W_valE = 64'h99;
    tick();
    check("rst2_icode", E_icode, 4'h1);
    idle();
    decode(4'h6, 4'h0, 4'h2, 4'h4, 64'h0, 64'h0);
    tick();
    check("rst2_reg2", E_valA, 64'd0);
    check("rst2_reg4", E_valB, 64'h200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
